// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and oversampling constants shared by receiver and transmitter
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // Tick indices within one oversampled bit period
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Clocks per oversample tick, truncated, never below one
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq / (baud * OVERSAMPLE) < 1) ? 1 : clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle tick at BAUD*16 Hz, restartable for start-edge alignment
//   clk       system clock
//   rst_n     synchronous active-low reset
//   restart_i forces the divider back to 0
//   tick_o    one-cycle oversample tick
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CW'(DIV - 1));
        cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with one-byte hold register, overrun and framing flags
//   clk/rst_n    system clock, synchronous active-low reset
//   RsRx         asynchronous serial line, idle high, LSB first
//   rx_ready     consumer takes the held byte when high with rx_valid
//   clr_overrun  clears the sticky overrun flag
//   rx_data      held byte, rx_valid marks it unconsumed
//   frame_err    one-cycle pulse on a low stop bit
//   overrun      sticky, a good byte was dropped because the hold was full
//   last_two     {older, newer} of the last two good bytes
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RsRx,
    input  logic        rx_ready,
    input  logic        clr_overrun,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] last_two
);

    logic [1:0]  sync_q, sync_d;
    logic [2:0]  state_q, state_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic [15:0] last_two_q, last_two_d;
    logic        rx_s, tick, restart, good, bad, load;

    baud_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d     = {sync_q[0], RsRx};
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        restart    = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        case (state_q)
            ST_IDLE: if (!rx_s) begin
                state_d    = ST_START;
                tick_cnt_d = '0;
                restart    = 1'b1;
            end
            ST_START: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == MID_TICK) begin
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            // The 4-bit tick counter wraps to 0 after LAST_TICK, realigning to the next bit centre
            ST_DATA: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == LAST_TICK) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == LAST_TICK) begin
                    good    = rx_s;
                    bad     = !rx_s;
                    state_d = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        load        = good && (!rx_valid_q || rx_ready);
        rx_data_d   = load ? shift_q : rx_data_q;
        rx_valid_d  = load ? 1'b1 : (rx_valid_q && !rx_ready);
        overrun_d   = (good && !load) ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
        last_two_d  = good ? {last_two_q[7:0], shift_q} : last_two_q;
        frame_err_d = bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            last_two_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            last_two_q  <= last_two_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign last_two  = last_two_q;

endmodule
